// File: rtl/fm_audio_i2s.sv
// fm_audio_i2s: mixes FM and PCM stereo samples with master volume and saturation, then serializes them as I2S.
// Sticky clip flags exist only when AUDIO_MIX_CLIP_DETECT_EN is defined.
module fm_audio_i2s #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fm_l,
  input  logic [15:0] fm_r,
  input  logic [15:0] pcm_l,
  input  logic [15:0] pcm_r,
  input  logic [7:0]  master_vol,
  input  logic        clip_clr,
  output logic        frame_start,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        clip_l,
  output logic        clip_r
);
  localparam int DW = $clog2(BCLK_DIV);

  // Returns {clip_event, saturated_word}.
  function automatic logic [16:0] mix(input logic [15:0] a, input logic [15:0] b, input logic [7:0] v);
    logic signed [16:0] s;
    logic signed [25:0] p;
    logic signed [18:0] q;
    s = $signed({a[15], a}) + $signed({b[15], b});
    p = $signed({{9{s[16]}}, s}) * $signed({18'd0, v});
    q = p[25:7];
    return q > 19'sd32767 ? {1'b1, 16'h7fff} : q < -19'sd32768 ? {1'b1, 16'h8000} : {1'b0, q[15:0]};
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d, lr_q, lr_d, sd_q, sd_d, fs_q, fs_d;
  logic [5:0]    bit_q, bit_d;
  logic [15:0]   fml_q, fmr_q, pcml_q, pcmr_q, outl_q, outr_q, word;
  logic [7:0]    vol_q;
  logic [16:0]   mix_l, mix_r;
  logic          tc, fall, wrap;
  logic [4:0]    n;

  always_comb begin
    tc = div_q == DW'(BCLK_DIV - 1);
    fall = tc & bclk_q;
    wrap = fall & (bit_q == 6'd63);
    div_d = tc ? '0 : div_q + DW'(1);
    bclk_d = bclk_q ^ tc;
    bit_d = bit_q + {5'd0, fall};
    n = bit_d[4:0];
    word = bit_d[5] ? outr_q : outl_q;
    lr_d = bit_d[5];
    sd_d = fall ? (n != 5'd0 && n <= 5'd16 && word[4'(5'd16 - n)]) : sd_q;
    fs_d = wrap;
    mix_l = mix(fml_q, pcml_q, vol_q);
    mix_r = mix(fmr_q, pcmr_q, vol_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      lr_q   <= 1'b0;
      sd_q   <= 1'b0;
      fs_q   <= 1'b0;
      bit_q  <= '0;
      fml_q  <= '0;
      fmr_q  <= '0;
      pcml_q <= '0;
      pcmr_q <= '0;
      vol_q  <= '0;
      outl_q <= '0;
      outr_q <= '0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      lr_q   <= lr_d;
      sd_q   <= sd_d;
      fs_q   <= fs_d;
      bit_q  <= bit_d;
      if (wrap) begin
        fml_q  <= fm_l;
        fmr_q  <= fm_r;
        pcml_q <= pcm_l;
        pcmr_q <= pcm_r;
        vol_q  <= master_vol;
      end
      // Mixer result lands one clk after the latch, well before slot 1.
      if (fs_q) begin
        outl_q <= mix_l[15:0];
        outr_q <= mix_r[15:0];
      end
    end
  end

  assign frame_start = fs_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lr_q;
  assign i2s_sdata   = sd_q;

`ifdef AUDIO_MIX_CLIP_DETECT_EN
  logic clipl_q, clipr_q;

  // A clip event at load wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clipl_q <= 1'b0;
      clipr_q <= 1'b0;
    end else begin
      clipl_q <= (fs_q & mix_l[16]) | (clipl_q & ~clip_clr);
      clipr_q <= (fs_q & mix_r[16]) | (clipr_q & ~clip_clr);
    end
  end

  assign clip_l = clipl_q;
  assign clip_r = clipr_q;
`else
  logic unused_clip;

  assign unused_clip = ^{clip_clr, mix_l[16], mix_r[16]};
  assign clip_l = 1'b0;
  assign clip_r = 1'b0;
`endif
endmodule
